// File: rtl/hack_ctrl_pkg.sv
// Shared types and constants for the Hack CPU fetch/execute controller.
package hack_ctrl_pkg;

  typedef enum logic [1:0] {
    StRst,
    StHalt,
    StFetch,
    StExec
  } ctrl_state_e;

  // Jump field bit positions within a C-instruction.
  localparam int unsigned JumpBitJ1 = 2;
  localparam int unsigned JumpBitJ2 = 1;
  localparam int unsigned JumpBitJ3 = 0;

  localparam int unsigned CInstrBit          = 15;
  localparam int unsigned ImemTimeoutDefault = 15;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump decision for a Hack instruction given the ALU flags.
module hack_jump_cond
  import hack_ctrl_pkg::*;
(
  input  logic [15:0] instr_i,
  input  logic        alu_zr_i,
  input  logic        alu_ng_i,
  output logic        jump_o
);

  always_comb begin
    jump_o = 1'b0;
    if (instr_i[CInstrBit]) begin
      jump_o = (instr_i[JumpBitJ1] & alu_ng_i) |
               (instr_i[JumpBitJ2] & alu_zr_i) |
               (instr_i[JumpBitJ3] & ~alu_ng_i & ~alu_zr_i);
    end
  end

endmodule

// File: rtl/hack_fetch_ctrl.sv
// Hack CPU fetch/execute sequencer: run/step/halt control, fetch timeout and retire count.
module hack_fetch_ctrl
  import hack_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_TIMEOUT = ImemTimeoutDefault
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic        step_i,
  input  logic        halt_req_i,
  input  logic [15:0] pc_out_i,
  output logic        pc_reset_o,
  output logic        pc_load_o,
  output logic        pc_incr_o,
  output logic        imem_req_o,
  output logic [14:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  output logic [15:0] instr_o,
  output logic        instr_valid_o,
  input  logic        exec_done_i,
  input  logic        alu_zr_i,
  input  logic        alu_ng_i,
  output logic        halted_o,
  output logic        fault_o,
  output logic [15:0] retired_o
);

  localparam int unsigned WaitW = $clog2(IMEM_TIMEOUT + 1);

  ctrl_state_e      state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fault_q, fault_d;
  logic [15:0]      retired_q, retired_d;
  logic             halt_pend_q, halt_pend_d;
  logic             step_mode_q, step_mode_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             jump;
  logic             unused_pc_msb;

  hack_jump_cond u_jump_cond (
    .instr_i  (instr_q),
    .alu_zr_i (alu_zr_i),
    .alu_ng_i (alu_ng_i),
    .jump_o   (jump)
  );

  // Fetch address space is 15 bits; PC bit 15 wraps away.
  assign imem_addr_o   = pc_out_i[14:0];
  assign unused_pc_msb = pc_out_i[15];

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fault_d       = fault_q;
    retired_d     = retired_q;
    halt_pend_d   = halt_pend_q;
    step_mode_d   = step_mode_q;
    wait_d        = wait_q;
    pc_reset_o    = 1'b0;
    pc_load_o     = 1'b0;
    pc_incr_o     = 1'b0;
    imem_req_o    = 1'b0;
    halted_o      = 1'b0;

    unique case (state_q)
      StRst: begin
        pc_reset_o  = 1'b1;
        halt_pend_d = 1'b0;
        step_mode_d = 1'b0;
        wait_d      = '0;
        state_d     = StHalt;
      end
      StHalt: begin
        halted_o = 1'b1;
        if (run_i) begin
          step_mode_d = 1'b0;
          state_d     = StFetch;
        end else if (step_i) begin
          step_mode_d = 1'b1;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        imem_req_o = 1'b1;
        if (halt_req_i) halt_pend_d = 1'b1;
        if (imem_ack_i) begin
          instr_d       = imem_data_i;
          instr_valid_d = 1'b1;
          wait_d        = '0;
          state_d       = StExec;
        end else if (wait_q == WaitW'(IMEM_TIMEOUT - 1)) begin
          fault_d     = 1'b1;
          wait_d      = '0;
          halt_pend_d = 1'b0;
          step_mode_d = 1'b0;
          state_d     = StHalt;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StExec: begin
        if (halt_req_i) halt_pend_d = 1'b1;
        if (exec_done_i) begin
          pc_load_o = jump;
          pc_incr_o = ~jump;
          retired_d = retired_q + 16'd1;
          // A halt_req arriving in the boundary cycle itself still wins over run.
          if (halt_pend_q || halt_req_i || step_mode_q || !run_i) begin
            halt_pend_d = 1'b0;
            step_mode_d = 1'b0;
            state_d     = StHalt;
          end else begin
            state_d = StFetch;
          end
        end
      end
      default: state_d = StRst;
    endcase

    // A reset abandons the instruction in flight, so the PC must not move.
    if (reset_i) begin
      pc_load_o = 1'b0;
      pc_incr_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StRst;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      retired_q     <= '0;
      halt_pend_q   <= 1'b0;
      step_mode_q   <= 1'b0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      retired_q     <= retired_d;
      halt_pend_q   <= halt_pend_d;
      step_mode_q   <= step_mode_d;
      wait_q        <= wait_d;
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign fault_o       = fault_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_hack_fetch_ctrl.sv
// Scoreboarded bench for hack_fetch_ctrl with a behavioural PC register and imem/exec responders.
module tb_hack_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, step, halt_req;
  logic [15:0] pc_out;
  logic        pc_reset, pc_load, pc_incr;
  logic        imem_req, imem_ack;
  logic [14:0] imem_addr;
  logic [15:0] imem_data, instr;
  logic        instr_valid, exec_done, alu_zr, alu_ng;
  logic        halted, fault;
  logic [15:0] retired;
  logic [15:0] a_reg;

  int n_total = 0;
  int n_bad   = 0;
  int exp_ret = 0;

  logic [31:0] fetch_q[$];
  logic [31:0] act_q[$];

  localparam logic [1:0] ActLoad = 2'b10;
  localparam logic [1:0] ActIncr = 2'b01;

  always #5 clk = ~clk;

  hack_fetch_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .run_i         (run),
    .step_i        (step),
    .halt_req_i    (halt_req),
    .pc_out_i      (pc_out),
    .pc_reset_o    (pc_reset),
    .pc_load_o     (pc_load),
    .pc_incr_o     (pc_incr),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .exec_done_i   (exec_done),
    .alu_zr_i      (alu_zr),
    .alu_ng_i      (alu_ng),
    .halted_o      (halted),
    .fault_o       (fault),
    .retired_o     (retired)
  );

  // Behavioural program counter driven by the controller's strobes.
  always @(posedge clk) begin
    if (pc_reset)     pc_out <= 16'h0000;
    else if (pc_load) pc_out <= a_reg;
    else if (pc_incr) pc_out <= pc_out + 16'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop side: fetch addresses and PC strobes observed mid-cycle.
  always @(negedge clk) begin
    if (imem_req && imem_ack) begin
      if (fetch_q.size() == 0) check_eq("fetch_extra", {17'd0, imem_addr}, 32'hFFFF_FFFF);
      else check_eq("fetch_addr", {17'd0, imem_addr}, fetch_q.pop_front());
    end
    if (pc_load || pc_incr) begin
      if (act_q.size() == 0) check_eq("pc_act_extra", {30'd0, pc_load, pc_incr}, 32'd0);
      else check_eq("pc_act", {30'd0, pc_load, pc_incr}, act_q.pop_front());
    end
    if ((32'(pc_reset) + 32'(pc_load) + 32'(pc_incr)) > 32'd1)
      check_eq("pc_mutex", {29'd0, pc_reset, pc_load, pc_incr}, 32'd0);
  end

  task automatic do_instr(input logic [15:0] exp_addr, input logic [15:0] ins,
                          input logic zr, input logic ng, input int ack_dly,
                          input int done_dly, input logic [1:0] exp_act,
                          input logic hreq, input logic exp_halt);
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    check_eq("req_seen", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < ack_dly; i++) begin
      if (hreq && i == 0) halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
    end
    fetch_q.push_back({16'd0, exp_addr});
    imem_ack  = 1'b1;
    imem_data = ins;
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'hDEAD;
    check_eq("instr_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("instr", {16'd0, instr}, {16'd0, ins});
    for (int i = 0; i < done_dly; i++) begin
      tick();
      check_eq("instr_valid_off", {31'd0, instr_valid}, 32'd0);
    end
    alu_zr    = zr;
    alu_ng    = ng;
    exec_done = 1'b1;
    act_q.push_back({30'd0, exp_act});
    tick();
    exec_done = 1'b0;
    alu_zr    = 1'b0;
    alu_ng    = 1'b0;
    exp_ret++;
    check_eq("retired", {16'd0, retired}, 32'(exp_ret));
    check_eq("halted_after", {31'd0, halted}, {31'd0, exp_halt});
  endtask

  initial begin
    int n;
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    imem_ack = 1'b0; imem_data = 16'h0; exec_done = 1'b0;
    alu_zr = 1'b0; alu_ng = 1'b0; a_reg = 16'h0100;
    tick();
    tick();
    check_eq("rst_pc_reset", {31'd0, pc_reset}, 32'd1);
    check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_pc_strobes", {30'd0, pc_load, pc_incr}, 32'd0);
    check_eq("rst_retired", {16'd0, retired}, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    check_eq("rst_instr", {16'd0, instr}, 32'd0);
    check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_pc_reset_last", {31'd0, pc_reset}, 32'd1);
    tick();
    check_eq("pc_reset_one_cycle", {31'd0, pc_reset}, 32'd0);
    check_eq("halted_after_rst", {31'd0, halted}, 32'd1);

    run = 1'b1;
    tick();
    do_instr(16'h0000, 16'h0005, 0, 0, 1, 0, ActIncr, 0, 0);
    do_instr(16'h0001, 16'h0010, 0, 0, 0, 2, ActIncr, 0, 0);
    do_instr(16'h0002, 16'hE302, 1, 0, 0, 0, ActLoad, 0, 0);
    do_instr(16'h0100, 16'hE302, 0, 0, 1, 1, ActIncr, 0, 0);
    do_instr(16'h0101, 16'hE307, 0, 1, 0, 0, ActLoad, 0, 0);
    do_instr(16'h0100, 16'h7FFF, 1, 0, 0, 0, ActIncr, 0, 0);
    do_instr(16'h0101, 16'hE301, 0, 0, 0, 1, ActLoad, 0, 0);
    do_instr(16'h0100, 16'hE304, 1, 0, 0, 0, ActIncr, 0, 0);
    a_reg = 16'h7FFF;
    do_instr(16'h0101, 16'hE307, 1, 0, 0, 0, ActLoad, 0, 0);
    do_instr(16'h7FFF, 16'h0000, 0, 0, 0, 0, ActIncr, 0, 0);
    // halt_req during fetch with run held high.
    do_instr(16'h0000, 16'h0001, 0, 0, 2, 0, ActIncr, 1, 1);
    run = 1'b0;
    tick();
    check_eq("stay_halted", {31'd0, halted}, 32'd1);

    step = 1'b1;
    tick();
    step = 1'b0;
    do_instr(16'h0001, 16'h0001, 0, 0, 0, 1, ActIncr, 0, 1);
    tick();
    tick();
    check_eq("step_one_only", {30'd0, halted, imem_req}, 32'd2);

    step = 1'b1;
    run  = 1'b1;
    tick();
    step = 1'b0;
    do_instr(16'h0002, 16'h0001, 0, 0, 0, 0, ActIncr, 0, 0);
    run = 1'b0;
    do_instr(16'h0003, 16'h0001, 0, 0, 1, 0, ActIncr, 0, 1);

    run = 1'b1;
    tick();
    run = 1'b0;
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      tick();
    end
    check_eq("timeout_cycles", 32'(n), 32'd15);
    check_eq("timeout_fault", {31'd0, fault}, 32'd1);
    check_eq("timeout_halted", {31'd0, halted}, 32'd1);

    run = 1'b1;
    tick();
    run = 1'b0;
    do_instr(16'h0004, 16'h1234, 0, 0, 0, 0, ActIncr, 0, 1);
    check_eq("fault_sticky", {31'd0, fault}, 32'd1);

    imem_ack = 1'b1; imem_data = 16'hBEEF; exec_done = 1'b1;
    #1;
    check_eq("halt_no_strobe", {30'd0, pc_load, pc_incr}, 32'd0);
    tick();
    tick();
    imem_ack = 1'b0; exec_done = 1'b0;
    check_eq("halt_ignore_ack", {16'd0, instr}, 32'h1234);
    check_eq("halt_ignore_done", {16'd0, retired}, 32'(exp_ret));
    check_eq("halt_ignore_state", {31'd0, halted}, 32'd1);

    run = 1'b1;
    tick();
    fetch_q.push_back(32'h0005);
    imem_ack = 1'b1; imem_data = 16'hE307;
    tick();
    imem_ack = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("abort_no_strobe", {30'd0, pc_load, pc_incr}, 32'd0);
    tick();
    reset = 1'b0;
    check_eq("abort_rst_state", {31'd0, pc_reset}, 32'd1);
    check_eq("abort_retired", {16'd0, retired}, 32'd0);
    check_eq("abort_fault_clr", {31'd0, fault}, 32'd0);
    exec_done = 1'b1;
    #1;
    check_eq("rst_ignore_done", {30'd0, pc_load, pc_incr}, 32'd0);
    tick();
    exec_done = 1'b0;
    check_eq("abort_halted", {31'd0, halted}, 32'd1);
    tick();
    check_eq("refetch_addr", {16'd0, imem_req, imem_addr}, 32'h8000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    check_eq("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check_eq("act_q_drained", 32'(act_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_fetch_ctrl.md
HACK_FETCH_CTRL -- requirements
Module: hack_fetch_ctrl

Interface
REQ-001 Parameter: IMEM_TIMEOUT, default 15, max cycles to wait for imem_ack before faulting.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 run  input  1  level; 1 = free-run, 0 = stop at next instruction boundary.
REQ-005 step  input  1  pulse; in HALT, execute exactly one instruction.
REQ-006 halt_req  input  1  pulse; request halt at next instruction boundary.
REQ-007 pc_out  input  16  current program counter value.
REQ-008 pc_reset  output  1  clear PC at next edge.
REQ-009 pc_load  output  1  load PC from A register at next edge.
REQ-010 pc_incr  output  1  increment PC at next edge.
REQ-011 imem_req  output  1  instruction fetch request.
REQ-012 imem_addr  output  15  fetch address.
REQ-013 imem_ack  input  1  fetch data valid this cycle.
REQ-014 imem_data  input  16  fetched instruction.
REQ-015 instr  output  16  latched current instruction.
REQ-016 instr_valid  output  1  one-cycle pulse: instr ready for execution.
REQ-017 exec_done  input  1  execute stage finished; alu_zr/alu_ng valid this cycle.
REQ-018 alu_zr  input  1  ALU output == 0.
REQ-019 alu_ng  input  1  ALU output < 0.
REQ-020 halted  output  1  1 while in HALT.
REQ-021 fault  output  1  sticky fetch-timeout flag.
REQ-022 retired  output  16  count of completed instructions.

Function
REQ-023 FSM states SHALL be RST, HALT, FETCH, EXEC.
REQ-024 RST: pc_reset=1 for exactly one cycle, then HALT.
REQ-025 HALT: halted=1, imem_req=0; run=1 -> FETCH; else step=1 -> FETCH with step_mode set; run and step together -> run wins, step_mode clear.
REQ-026 FETCH: imem_req=1, imem_addr=pc_out[14:0]; on imem_ack, instr<=imem_data, -> EXEC.
REQ-027 FETCH wait counter SHALL count cycles without ack; on reaching IMEM_TIMEOUT, set fault, -> HALT, imem_req deasserts next cycle.
REQ-028 instr_valid SHALL be 1 only in the first EXEC cycle (ack-to-valid latency 1 cycle).
REQ-029 EXEC: wait for exec_done (may arrive in the first EXEC cycle); in the exec_done cycle drive exactly one of pc_load/pc_incr combinationally.
REQ-030 Jump: instr[15]=0 (A-instr) -> no jump; else jump=(instr[2]&alu_ng)|(instr[1]&alu_zr)|(instr[0]&~alu_ng&~alu_zr).
REQ-031 jump=1 -> pc_load=1; else pc_incr=1; pc_reset/pc_load/pc_incr SHALL be mutually exclusive every cycle.
REQ-032 After exec_done: retired+=1 (16-bit wrap 0xFFFF->0x0000); -> HALT if halt pending, step_mode, or run=0; else FETCH.
REQ-033 halt_req in FETCH/EXEC SHALL latch as halt pending, cleared on entering HALT; halt_req in HALT ignored.
REQ-034 halt_req and run=1 in the same boundary cycle -> halt wins.
REQ-035 PC wrap: pc_out 0x7FFF+1 -> imem_addr 0x0000 (bit 15 ignored).
REQ-036 imem_ack outside FETCH and exec_done outside EXEC SHALL be ignored.

Reset
REQ-037 reset SHALL force state RST next cycle from any state, abandoning any fetch/exec in flight.
REQ-038 Reset values: instr=0, instr_valid=0, imem_req=0, pc_load=0, pc_incr=0, fault=0, retired=0, halt pending=0, step_mode=0, wait counter=0; pc_reset=1 in the RST cycle.
REQ-039 fault SHALL clear only on reset.

Structure
REQ-040 Package hack_ctrl_pkg SHALL hold the state enum, jump-bit positions (J1=2, J2=1, J3=0), C-instr bit (15) and default IMEM_TIMEOUT.
REQ-041 Jump decode SHALL be a combinational sub-module hack_jump_cond (instr, alu_zr, alu_ng -> jump).
REQ-042 Budget 120-400 lines RTL including sub-module.

Verification
REQ-043 Reset, run=1, ack 1 cycle after req, instr 0x0005 -> pc_reset 1 cycle, fetch addr 0x0000, instr_valid 1 cycle, pc_incr on exec_done, next fetch addr 0x0001, retired=1.
REQ-044 instr 0xE302 (JEQ) with alu_zr=1 -> pc_load=1, pc_incr=0; same with alu_zr=0 -> pc_incr=1.
REQ-045 instr 0xE307 (JMP) any flags -> pc_load; instr 0x7FFF (A-instr, low bits 111) -> pc_incr.
REQ-046 Halted, pulse step -> exactly one fetch/exec, retired+1, halted=1 again; step+run same cycle -> free-run.
REQ-047 imem_ack withheld 15 cycles -> fault=1, halted=1; fault holds until reset.
REQ-048 halt_req mid-EXEC then reset before exec_done -> no pc_load/pc_incr, RST next cycle, retired=0.
